// File: rtl/mem_cache_unit.sv
// MEM-stage data cache: 1/2-way set-associative, write-through, no-write-allocate.
// Drives the pipeline freeze, gates write-back, and runs a one-set-per-cycle invalidate.
module mem_cache_unit #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 2,
  parameter int SETS       = 64,
  parameter int WAYS       = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         mem_r_en,
  input  logic                         mem_w_en,
  input  logic [ADDR_W-1:0]            address,
  input  logic [DATA_W-1:0]            wdata,
  input  logic                         wb_en_in,
  input  logic                         invalidate_all,
  output logic [DATA_W-1:0]            rdata,
  output logic                         freeze,
  output logic                         wb_en_out,
  output logic                         flush_busy,
  output logic                         sram_rd_en,
  output logic                         sram_wr_en,
  output logic [ADDR_W-1:0]            sram_address,
  output logic [DATA_W-1:0]            sram_wdata,
  input  logic [LINE_WORDS*DATA_W-1:0] sram_rdata,
  input  logic                         sram_ready
);

  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W - 2;
  localparam int LINE_W = LINE_WORDS * DATA_W;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_MISS = 2'd1;
  localparam logic [1:0] WR_THRU = 2'd2;
  localparam logic [1:0] FLUSH   = 2'd3;

  logic [1:0]        state;
  logic              pend;
  logic [IDX_W-1:0]  flush_cnt;
  logic [SETS-1:0]   valid [WAYS];
  logic [SETS-1:0]   lru;
  logic [TAG_W-1:0]  tags  [WAYS][SETS];
  logic [LINE_W-1:0] lines [WAYS][SETS];

  logic [OFF_W-1:0]  off;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [WAYS-1:0]   hit;
  logic [WAYS-1:0]   victim;
  logic [DATA_W-1:0] hit_word;
  logic [DATA_W-1:0] fill_word;
  logic              req;
  logic              pend_eff;
  logic              unused_bits;

  assign off         = address[OFF_W+1:2];
  assign idx         = address[OFF_W+2 +: IDX_W];
  assign tag         = address[ADDR_W-1 -: TAG_W];
  assign unused_bits = ^address[1:0];
  assign req         = mem_r_en | mem_w_en;
  assign pend_eff    = pend | invalidate_all;
  assign fill_word   = sram_rdata[off*DATA_W +: DATA_W];

  always_comb begin
    hit      = '0;
    hit_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[w][idx] && tags[w][idx] == tag) begin
        hit[w]   = 1'b1;
        hit_word = lines[w][idx][off*DATA_W +: DATA_W];
      end
    end
  end

  // Prefer an empty way (way 0 first); otherwise evict the LRU way.
  generate
    if (WAYS == 1) begin : g_dm
      assign victim = 1'b1;
    end else begin : g_2w
      always_comb begin
        if (!valid[0][idx])      victim = 2'b01;
        else if (!valid[1][idx]) victim = 2'b10;
        else if (lru[idx])       victim = 2'b10;
        else                     victim = 2'b01;
      end
    end
  endgenerate

  always_comb begin
    freeze = 1'b0;
    rdata  = '0;
    unique case (state)
      IDLE: begin
        if (pend_eff) begin
          freeze = req;
        end else if (mem_w_en) begin
          freeze = 1'b1;
        end else if (mem_r_en) begin
          freeze = ~|hit;
          rdata  = hit_word;
        end
      end
      RD_MISS: begin
        freeze = ~sram_ready;
        if (sram_ready) rdata = fill_word;
      end
      WR_THRU: freeze = ~sram_ready;
      FLUSH:   freeze = req;
      default: freeze = 1'b0;
    endcase
  end

  assign wb_en_out    = wb_en_in & ~freeze;
  assign flush_busy   = (state == FLUSH);
  assign sram_rd_en   = (state == RD_MISS);
  assign sram_wr_en   = (state == WR_THRU);
  assign sram_wdata   = wdata;
  assign sram_address = (state == RD_MISS)
                      ? (address & ~ADDR_W'(LINE_WORDS*4-1))
                      : address;

  // lru[set] holds the index of the least recently used way.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      pend      <= 1'b0;
      flush_cnt <= '0;
      lru       <= '0;
      for (int w = 0; w < WAYS; w++) valid[w] <= '0;
    end else begin
      if (invalidate_all) pend <= 1'b1;
      unique case (state)
        IDLE: begin
          if (pend_eff) begin
            state <= FLUSH;
            pend  <= 1'b0;
          end else if (mem_w_en) begin
            state <= WR_THRU;
          end else if (mem_r_en) begin
            if (|hit) lru[idx] <= hit[0];
            else      state    <= RD_MISS;
          end
        end
        RD_MISS: begin
          if (sram_ready) begin
            state    <= IDLE;
            lru[idx] <= victim[0];
            for (int w = 0; w < WAYS; w++)
              if (victim[w]) valid[w][idx] <= 1'b1;
          end
        end
        WR_THRU: begin
          if (sram_ready) begin
            state <= IDLE;
            if (|hit) lru[idx] <= hit[0];
          end
        end
        FLUSH: begin
          for (int w = 0; w < WAYS; w++) valid[w][flush_cnt] <= 1'b0;
          lru[flush_cnt] <= 1'b0;
          flush_cnt      <= flush_cnt + 1'b1;
          if (flush_cnt == IDX_W'(SETS-1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    for (int w = 0; w < WAYS; w++) begin
      if (!reset && state == RD_MISS && sram_ready && victim[w]) begin
        lines[w][idx] <= sram_rdata;
        tags[w][idx]  <= tag;
      end else if (!reset && state == WR_THRU && sram_ready && hit[w]) begin
        lines[w][idx][off*DATA_W +: DATA_W] <= wdata;
      end
    end
  end

endmodule
